// File: rtl/demux_stream.sv
// Two-way stream demultiplexer: steers each accepted word to port A or B, each with a 2-entry FIFO.
// Optional per-port delivery counters are built when DEMUX_STREAM_CNT_EN is defined.
module demux_stream #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [7:0]       a_cnt,
    output logic [7:0]       b_cnt
);

    localparam int unsigned NPORT = 2;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 8;

    logic [NPORT-1:0]            full;
    logic [NPORT-1:0]            nonempty;
    logic [NPORT-1:0]            out_ready;
    logic [NPORT-1:0]            push;
    logic [NPORT-1:0]            pop;
    logic [NPORT-1:0][WIDTH-1:0] head;
    logic [NPORT-1:0][CNT_W-1:0] cnt;

    assign out_ready = {b_ready, a_ready};

    // Only registered full flags feed in_ready; a same-cycle pop never frees a full FIFO.
    assign in_ready = in_sel ? !full[1] : !full[0];

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [1:0]       count_q, count_d;
        logic             wr_ptr_q, wr_ptr_d;
        logic             rd_ptr_q, rd_ptr_d;
        logic [WIDTH-1:0] mem_q [DEPTH];

        assign push[p]     = in_valid && in_ready && (in_sel == 1'(p));
        assign pop[p]      = nonempty[p] && out_ready[p];
        assign full[p]     = (count_q == 2'd2);
        assign nonempty[p] = (count_q != 2'd0);
        assign head[p]     = mem_q[rd_ptr_q];

        // Pointer and occupancy update.
        always_comb begin
            count_d  = count_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (push[p]) wr_ptr_d = !wr_ptr_q;
            if (pop[p])  rd_ptr_d = !rd_ptr_q;
            case ({push[p], pop[p]})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q  <= 2'd0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                mem_q[0] <= '0;
                mem_q[1] <= '0;
            end else begin
                count_q  <= count_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                if (push[p]) mem_q[wr_ptr_q] <= in_data;
            end
        end

`ifdef DEMUX_STREAM_CNT_EN
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Delivered-word counter, wraps naturally at 2**CNT_W.
        assign cnt_d = pop[p] ? cnt_q + CNT_W'(1) : cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign cnt[p] = cnt_q;
`else
        assign cnt[p] = '0;
`endif
    end

    assign a_data  = head[0];
    assign a_valid = nonempty[0];
    assign a_cnt   = cnt[0];
    assign b_data  = head[1];
    assign b_valid = nonempty[1];
    assign b_cnt   = cnt[1];

endmodule
